// File: rtl/wt_dcache_rd_arbiter_pkg.sv
// Shared types and sizing constants for the write-through dcache read-port arbiter.
package wt_dcache_rd_arbiter_pkg;

    localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned DCACHE_TAG_WIDTH    = 20;
    localparam int unsigned DCACHE_RD_MAX_STALL = 16;

    typedef struct packed {
        logic                           tag_only;
        logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
        logic [DCACHE_OFFSET_WIDTH-1:0] off;
        logic [DCACHE_TAG_WIDTH-1:0]    tag;
    } rd_arb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PROMO,
        GNT_HIGH,
        GNT_LOW
    } gnt_class_e;

endpackage

// File: rtl/wt_dcache_rd_arbiter_if.sv
// Read-request / bank-select / response bundle between the read ports and the arbiter.
interface wt_dcache_rd_arbiter_if
    import wt_dcache_rd_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts = 3,
    parameter int unsigned IdxWidth = DCACHE_CL_IDX_WIDTH,
    parameter int unsigned OffWidth = DCACHE_OFFSET_WIDTH,
    parameter int unsigned TagWidth = DCACHE_TAG_WIDTH
);

    logic [NumPorts-1:0]               rd_req_i;
    logic [NumPorts-1:0]               rd_prio_i;
    logic [NumPorts-1:0]               rd_tag_only_i;
    logic [NumPorts-1:0][IdxWidth-1:0] rd_idx_i;
    logic [NumPorts-1:0][OffWidth-1:0] rd_off_i;
    logic [NumPorts-1:0][TagWidth-1:0] rd_tag_i;
    logic                              wr_cl_vld_i;

    logic [NumPorts-1:0]               rd_ack_o;
    logic                              bank_req_o;
    logic [IdxWidth-1:0]               bank_idx_o;
    logic [OffWidth-1:0]               bank_off_o;
    logic                              bank_tag_only_o;
    logic                              rsp_vld_o;
    logic [NumPorts-1:0]               rsp_port_o;
    logic [TagWidth-1:0]               rsp_tag_o;
    logic [NumPorts-1:0]               starve_o;

    modport master (
        output rd_req_i, rd_prio_i, rd_tag_only_i, rd_idx_i, rd_off_i, rd_tag_i, wr_cl_vld_i,
        input  rd_ack_o, bank_req_o, bank_idx_o, bank_off_o, bank_tag_only_o,
               rsp_vld_o, rsp_port_o, rsp_tag_o, starve_o
    );

    modport slave (
        input  rd_req_i, rd_prio_i, rd_tag_only_i, rd_idx_i, rd_off_i, rd_tag_i, wr_cl_vld_i,
        output rd_ack_o, bank_req_o, bank_idx_o, bank_off_o, bank_tag_only_o,
               rsp_vld_o, rsp_port_o, rsp_tag_o, starve_o
    );

endinterface

// File: rtl/wt_dcache_rd_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr_i, wrapping modulo NumPorts.
module wt_dcache_rr_pick #(
    parameter  int unsigned NumPorts = 3,
    localparam int unsigned PtrW     = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [PtrW-1:0]     ptr_i,
    output logic [NumPorts-1:0] gnt_o,
    output logic [PtrW-1:0]     idx_o,
    output logic                vld_o
);

    logic [PtrW:0]   sum;
    logic [PtrW-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            // One spare bit holds ptr+i before folding back into range.
            sum = {1'b0, ptr_i} + (PtrW+1)'(i);
            if (sum >= (PtrW+1)'(NumPorts)) begin
                sum = sum - (PtrW+1)'(NumPorts);
            end
            pos = sum[PtrW-1:0];
            if (!vld_o && req_i[pos]) begin
                vld_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/wt_dcache_rd_arbiter.sv
// Dcache read-port arbiter: promoted > high-prio > low-prio, round-robin within each class,
// stall counters promote starved low-prio ports, winner registered for the response path.
module wt_dcache_rd_arbiter
    import wt_dcache_rd_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts = 3,
    parameter int unsigned MaxStall = DCACHE_RD_MAX_STALL,
    parameter int unsigned IdxWidth = DCACHE_CL_IDX_WIDTH,
    parameter int unsigned OffWidth = DCACHE_OFFSET_WIDTH,
    parameter int unsigned TagWidth = DCACHE_TAG_WIDTH
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    wt_dcache_rd_arbiter_if.slave bus
);

    localparam int unsigned PtrW = $clog2(NumPorts);
    localparam int unsigned CntW = $clog2(MaxStall + 1);

    logic [PtrW-1:0]     hi_ptr_q, hi_ptr_d, lo_ptr_q, lo_ptr_d;
    logic [CntW-1:0]     cnt_q [NumPorts];
    logic [CntW-1:0]     cnt_d [NumPorts];
    logic                rsp_vld_q, rsp_vld_d;
    logic [NumPorts-1:0] rsp_port_q, rsp_port_d;
    logic [TagWidth-1:0] rsp_tag_q, rsp_tag_d;

    logic [NumPorts-1:0] starve, promo_req, high_req, low_req, gnt;
    logic [NumPorts-1:0] promo_gnt, high_gnt, low_gnt;
    logic [PtrW-1:0]     promo_idx, high_idx, low_idx, win_idx, win_next;
    logic                promo_vld, high_vld, low_vld;
    gnt_class_e          gnt_class;

    logic [IdxWidth-1:0] bank_idx;
    logic [OffWidth-1:0] bank_off;
    logic [TagWidth-1:0] bank_tag;
    logic                bank_tag_only;

    // A port whose prio bit is high is never treated as promoted, even with a saturated count.
    always_comb begin
        starve = '0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            starve[k] = !bus.rd_prio_i[k] && (cnt_q[k] == CntW'(MaxStall));
        end
    end

    assign promo_req = bus.rd_req_i & starve;
    assign high_req  = bus.rd_req_i & bus.rd_prio_i;
    assign low_req   = bus.rd_req_i & ~bus.rd_prio_i;

    wt_dcache_rr_pick #(.NumPorts(NumPorts)) u_pick_promo (
        .req_i(promo_req), .ptr_i(lo_ptr_q), .gnt_o(promo_gnt), .idx_o(promo_idx), .vld_o(promo_vld)
    );
    wt_dcache_rr_pick #(.NumPorts(NumPorts)) u_pick_high (
        .req_i(high_req), .ptr_i(hi_ptr_q), .gnt_o(high_gnt), .idx_o(high_idx), .vld_o(high_vld)
    );
    wt_dcache_rr_pick #(.NumPorts(NumPorts)) u_pick_low (
        .req_i(low_req), .ptr_i(lo_ptr_q), .gnt_o(low_gnt), .idx_o(low_idx), .vld_o(low_vld)
    );

    always_comb begin
        gnt_class = GNT_NONE;
        gnt       = '0;
        win_idx   = '0;
        if (rst_ni && !bus.wr_cl_vld_i) begin
            if (promo_vld) begin
                gnt_class = GNT_PROMO;
                gnt       = promo_gnt;
                win_idx   = promo_idx;
            end else if (high_vld) begin
                gnt_class = GNT_HIGH;
                gnt       = high_gnt;
                win_idx   = high_idx;
            end else if (low_vld) begin
                gnt_class = GNT_LOW;
                gnt       = low_gnt;
                win_idx   = low_idx;
            end
        end
    end

    assign win_next = (win_idx == PtrW'(NumPorts - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        hi_ptr_d = hi_ptr_q;
        lo_ptr_d = lo_ptr_q;
        case (gnt_class)
            GNT_PROMO, GNT_LOW: lo_ptr_d = win_next;
            GNT_HIGH:           hi_ptr_d = win_next;
            default:            ;
        endcase
    end

    always_comb begin
        for (int unsigned k = 0; k < NumPorts; k++) begin
            cnt_d[k] = cnt_q[k];
            if (bus.rd_prio_i[k] || !bus.rd_req_i[k] || gnt[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] != CntW'(MaxStall)) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_comb begin
        bank_idx      = '0;
        bank_off      = '0;
        bank_tag      = '0;
        bank_tag_only = 1'b0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            if (gnt[k]) begin
                bank_idx      = bus.rd_idx_i[k];
                bank_off      = bus.rd_off_i[k];
                bank_tag      = bus.rd_tag_i[k];
                bank_tag_only = bus.rd_tag_only_i[k];
            end
        end
    end

    assign rsp_vld_d  = |gnt;
    assign rsp_port_d = gnt;
    assign rsp_tag_d  = bank_tag;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_ptr_q   <= '0;
            lo_ptr_q   <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= '0;
            rsp_tag_q  <= '0;
            for (int unsigned k = 0; k < NumPorts; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            hi_ptr_q   <= hi_ptr_d;
            lo_ptr_q   <= lo_ptr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_port_q <= rsp_port_d;
            rsp_tag_q  <= rsp_tag_d;
            for (int unsigned k = 0; k < NumPorts; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign bus.rd_ack_o        = gnt;
    assign bus.bank_req_o      = |gnt;
    assign bus.bank_idx_o      = bank_idx;
    assign bus.bank_off_o      = bank_off;
    assign bus.bank_tag_only_o = bank_tag_only;
    assign bus.rsp_vld_o       = rsp_vld_q;
    assign bus.rsp_port_o      = rsp_port_q;
    assign bus.rsp_tag_o       = rsp_tag_q;
    assign bus.starve_o        = starve;

endmodule

// File: doc/wt_dcache_rd_arbiter.md
Name: wt_dcache_rd_arbiter

Overview:
- Parametrised read-port arbiter for the write-through L1 dcache memory array. Replaces the fixed 3-port, fixed-priority read selection with NumPorts requesters, two priority classes, and round-robin fairness within each class.
- Prevents starvation by promoting a low-priority port after MaxStall consecutive denied cycles.
- Registers the winner so the response (data/hit) path is aligned one cycle later.
- Sits between the read controllers/write buffer and the tag/data SRAM banks.

Parameters:
- NumPorts, 3, number of read requesters (≥2).
- MaxStall, 16, consecutive denied cycles before a low-prio port is promoted (≥1).
- IdxWidth, DCACHE_CL_IDX_WIDTH, cacheline index width.
- OffWidth, DCACHE_OFFSET_WIDTH, byte offset width.
- TagWidth, DCACHE_TAG_WIDTH, tag width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rd_req_i  in  NumPorts  read request per port
- rd_prio_i  in  NumPorts  1 = high-priority port (static per port, may be sampled every cycle)
- rd_tag_only_i  in  NumPorts  request needs tag/valid only
- rd_idx_i  in  NumPorts x IdxWidth  per-port index
- rd_off_i  in  NumPorts x OffWidth  per-port offset
- rd_tag_i  in  NumPorts x TagWidth  per-port tag
- wr_cl_vld_i  in  1  cacheline refill/invalidate in progress; blocks all reads
- rd_ack_o  out  NumPorts  one-hot grant, same cycle as request
- bank_req_o  out  1  SRAM read enable
- bank_idx_o  out  IdxWidth  selected index
- bank_off_o  out  OffWidth  selected offset
- bank_tag_only_o  out  1  selected tag-only flag
- rsp_vld_o  out  1  registered: grant issued in previous cycle
- rsp_port_o  out  NumPorts  registered one-hot port of previous grant
- rsp_tag_o  out  TagWidth  registered tag for hit comparison
- starve_o  out  NumPorts  port currently promoted (debug/perf)

Behaviour:
- Reset: rd_ack_o=0, bank_req_o=0, rsp_vld_o=0, rsp_port_o=0, rsp_tag_o=0, starve_o=0. Both RR pointers=0; all stall counters=0.
- Grant is combinational: at most one rd_ack_o bit per cycle, never to a non-requesting port.
- bank_req_o = |rd_ack_o. Bank outputs mux from the granted port; they are 0 when there is no grant.
- wr_cl_vld_i=1: no grant, rd_ack_o=0. Stall counters still advance. RR pointers hold.
- Selection order:
  1. Promoted ports (starve_o=1), round-robin using the low pointer.
  2. High-prio requesters, round-robin using the high pointer.
  3. Low-prio requesters, round-robin using the low pointer.
- Round-robin: search starts at the class pointer and wraps modulo NumPorts. On a grant in a class, that class pointer becomes (winner+1) mod NumPorts, with wrap NumPorts-1 -> 0. A promoted grant updates the low pointer.
- Stall counter, per low-prio port, width $clog2(MaxStall+1):
  - Increments each cycle the port requests and is not granted, saturating at MaxStall.
  - Clears on grant or when rd_req_i drops.
  - starve_o[k] = (counter==MaxStall).
- High-prio ports never promote; their counters stay 0.
- Response register: rsp_vld_o, rsp_port_o and rsp_tag_o load from the current grant every cycle; rsp_vld_o=0 when there is no grant. Latency request->rsp_vld_o is 1 cycle.
- A requester must hold its request stable until acked; a dropped request is not an error and is simply not granted.
- rd_prio_i changing while a port is promoted: the port is treated as high-prio and its counter clears.
- Asynchronous reset mid-operation clears all state immediately. Any grant in flight produces no response.

Decomposition:
- wt_cache_pkg: add rd_arb_req_t struct {tag_only, idx, off, tag} and the constant DCACHE_RD_MAX_STALL=16.
- Sub-module wt_dcache_rr_pick (parametrised: request vector + pointer -> one-hot winner + valid). Instantiated three times: promoted, high, low.

Test Plan:
- NumPorts=3, prio=3'b011, ports 0,1 request continuously, port 2 idle, 4 cycles -> acks 001,010,001,010; rsp_port_o follows one cycle later.
- Port 2 (low) and port 0 (high) request continuously, MaxStall=4 -> port 2 starve_o rises after 4 denied cycles, then port 2 is acked in the next cycle and its counter clears.
- wr_cl_vld_i=1 for 3 cycles with all ports requesting -> rd_ack_o=0 and rsp_vld_o=0 next cycle; RR pointer unchanged; low counters advance by 3.
- NumPorts=5, all high-prio, pointer at 4, requests 5'b10001 -> port 4 wins, pointer wraps to 0; next cycle port 0 wins.
- Grant to port 1 in cycle t, rst_ni asserted in t+1 -> rsp_vld_o=0 immediately and all outputs at reset values.
- Single request, tag_only=1, idx=0x2A, tag=0x1234 -> bank_req_o=1, bank_idx_o=0x2A, bank_tag_only_o=1 same cycle; rsp_tag_o=0x1234 next cycle.
